regfile_2r1w_sb: RTL and testbench

//  - Register file: 2 read ports, 1 write port, with a per-register scoreboard (ready bits).
//  - It is the read side of the 32-bit register storage: decode reads operands here, and writeback writes results here.
//  - Each storage entry is one reg32 instance.
//  - Read ports are registered, with write-to-read bypass.
//  - The scoreboard tracks registers whose values are still pending from an in-flight producer.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/reg32.sv | 40 ++++
 rtl/regfile_2r1w_sb.sv | 135 +++++++++++++
 tb/tb_regfile_2r1w_sb.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the 2-read / 1-write register file.
//   NREGS      : number of architectural registers (power of 2, >= 2)
//   DW         : data width, fixed at 32 so each entry is one reg32
//   AW         : address width derived from NREGS
//   reg_addr_t : register index type
//   reg_data_t : register value type
package regfile_pkg;

  localparam int NREGS = 8;
  localparam int DW    = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] reg_data_t;

endpackage

// File: rtl/reg32.sv
// Single 32-bit storage register.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset, clears q to 0
//   set   in   synchronous set, forces q to all ones (has priority over we)
//   we    in   write enable
//   wdata in   value loaded when we=1
//   q     out  current register contents
module reg32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        set,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] q
);

  logic [31:0] q_q;
  logic [31:0] q_d;

  always_comb begin
    q_d = q_q;
    if (set) begin
      q_d = '1;
    end else if (we) begin
      q_d = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/regfile_2r1w_sb.sv
// Register file with two registered read ports, one write port and a
// per-register ready scoreboard. r0 is hard-wired to zero and always ready.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data writeback: stores data and marks the register ready
//   alloc_en/alloc_addr   issue: marks the register busy (producer in flight)
//   rdX_en/rdX_addr       read request, X in {0,1}
//   rdX_data/rdX_rdy      read response, one cycle after the request
//   rdX_vld               response valid; data/rdy hold while vld=0
// Handshake: a request is accepted on every edge where rdX_en=1 (no
// backpressure); the response appears after the following edge with vld=1.
// Reads observe the state as it is after the request edge: a same-cycle
// write is bypassed and a same-cycle alloc clears the returned rdy.
module regfile_2r1w_sb
  import regfile_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          alloc_en,
  input  logic [AW-1:0] alloc_addr,
  input  logic          rd0_en,
  input  logic [AW-1:0] rd0_addr,
  output logic [DW-1:0] rd0_data,
  output logic          rd0_rdy,
  output logic          rd0_vld,
  input  logic          rd1_en,
  input  logic [AW-1:0] rd1_addr,
  output logic [DW-1:0] rd1_data,
  output logic          rd1_rdy,
  output logic          rd1_vld
);

  logic      rst;
  reg_data_t entry [NREGS];

  logic [NREGS-1:0] ready_q;
  logic [NREGS-1:0] ready_d;

  reg_data_t rd0_data_q, rd0_data_d;
  reg_data_t rd1_data_q, rd1_data_d;
  logic      rd0_rdy_q, rd0_rdy_d;
  logic      rd1_rdy_q, rd1_rdy_d;
  logic      rd0_vld_q, rd1_vld_q;

  logic wr_live;
  logic alloc_live;

  assign rst        = ~rst_n;
  assign wr_live    = wr_en && (wr_addr != '0);
  assign alloc_live = alloc_en && (alloc_addr != '0);

  // Storage: entry 0 is constant zero, 1..NREGS-1 are reg32 instances.
  assign entry[0] = '0;

  for (genvar i = 1; i < NREGS; i++) begin : g_entry
    reg32 u_reg (
      .clk   (clk),
      .rst   (rst),
      .set   (1'b0),
      .we    (wr_en && (wr_addr == reg_addr_t'(i))),
      .wdata (wr_data),
      .q     (entry[i])
    );
  end

  // Scoreboard next state. Alloc is applied after write so that a newer
  // producer claiming the register in the same cycle leaves it busy.
  always_comb begin
    ready_d = ready_q;
    if (wr_live) begin
      ready_d[wr_addr] = 1'b1;
    end
    if (alloc_live) begin
      ready_d[alloc_addr] = 1'b0;
    end
    ready_d[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= '1;
    end else begin
      ready_q <= ready_d;
    end
  end

  // Read muxes with write bypass; rdy is taken from the post-update
  // scoreboard so both bypass and same-cycle alloc are covered.
  always_comb begin
    rd0_data_d = entry[rd0_addr];
    if (wr_live && (wr_addr == rd0_addr)) begin
      rd0_data_d = wr_data;
    end
    rd0_rdy_d = ready_d[rd0_addr];

    rd1_data_d = entry[rd1_addr];
    if (wr_live && (wr_addr == rd1_addr)) begin
      rd1_data_d = wr_data;
    end
    rd1_rdy_d = ready_d[rd1_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd0_data_q <= '0;
      rd0_rdy_q  <= 1'b0;
      rd0_vld_q  <= 1'b0;
      rd1_data_q <= '0;
      rd1_rdy_q  <= 1'b0;
      rd1_vld_q  <= 1'b0;
    end else begin
      rd0_vld_q <= rd0_en;
      rd1_vld_q <= rd1_en;
      if (rd0_en) begin
        rd0_data_q <= rd0_data_d;
        rd0_rdy_q  <= rd0_rdy_d;
      end
      if (rd1_en) begin
        rd1_data_q <= rd1_data_d;
        rd1_rdy_q  <= rd1_rdy_d;
      end
    end
  end

  assign rd0_data = rd0_data_q;
  assign rd0_rdy  = rd0_rdy_q;
  assign rd0_vld  = rd0_vld_q;
  assign rd1_data = rd1_data_q;
  assign rd1_rdy  = rd1_rdy_q;
  assign rd1_vld  = rd1_vld_q;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
module tb_regfile_2r1w_sb;
  import regfile_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en, alloc_en, rd0_en, rd1_en;
  logic [AW-1:0] wr_addr, alloc_addr, rd0_addr, rd1_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd0_data, rd1_data;
  logic          rd0_rdy, rd1_rdy, rd0_vld, rd1_vld;

  regfile_2r1w_sb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .rd0_en     (rd0_en),
    .rd0_addr   (rd0_addr),
    .rd0_data   (rd0_data),
    .rd0_rdy    (rd0_rdy),
    .rd0_vld    (rd0_vld),
    .rd1_en     (rd1_en),
    .rd1_addr   (rd1_addr),
    .rd1_data   (rd1_data),
    .rd1_rdy    (rd1_rdy),
    .rd1_vld    (rd1_vld)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] model_mem [NREGS];
  logic          model_rdy [NREGS];
  logic [DW:0]   hold0, hold1;          // last {rdy,data} seen per port
  logic [DW:0]   exp_q0[$], exp_q1[$];  // pending {rdy,data} per port

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      model_mem[i] = '0;
      model_rdy[i] = 1'b1;
    end
    hold0 = '0;
    hold1 = '0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // ---------------- driver ----------------
  task automatic idle();
    wr_en = 0; wr_addr = '0; wr_data = '0;
    alloc_en = 0; alloc_addr = '0;
    rd0_en = 0; rd0_addr = '0;
    rd1_en = 0; rd1_addr = '0;
  endtask

  // Apply one clock with current inputs; model the edge, then check outputs.
  task automatic step();
    logic e0, e1;
    e0 = rd0_en;
    e1 = rd1_en;
    if (wr_en && wr_addr != 0) begin
      model_mem[wr_addr] = wr_data;
      model_rdy[wr_addr] = 1'b1;
    end
    if (alloc_en && alloc_addr != 0) model_rdy[alloc_addr] = 1'b0;
    if (rd0_en) exp_q0.push_back({model_rdy[rd0_addr], model_mem[rd0_addr]});
    if (rd1_en) exp_q1.push_back({model_rdy[rd1_addr], model_mem[rd1_addr]});
    @(posedge clk);
    #1;
    check("rd0_vld", 64'(rd0_vld), 64'(e0));
    check("rd1_vld", 64'(rd1_vld), 64'(e1));
    if (e0) begin
      if (exp_q0.size() == 0) begin
        check("rd0_queue_empty", 64'(1), 64'(0));
      end else begin
        hold0 = exp_q0.pop_front();
      end
    end
    if (e1) begin
      if (exp_q1.size() == 0) begin
        check("rd1_queue_empty", 64'(1), 64'(0));
      end else begin
        hold1 = exp_q1.pop_front();
      end
    end
    check("rd0_data", 64'(rd0_data), 64'(hold0[DW-1:0]));
    check("rd0_rdy",  64'(rd0_rdy),  64'(hold0[DW]));
    check("rd1_data", 64'(rd1_data), 64'(hold1[DW-1:0]));
    check("rd1_rdy",  64'(rd1_rdy),  64'(hold1[DW]));
  endtask

  task automatic read0(input int a);
    idle(); rd0_en = 1; rd0_addr = AW'(a); step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    model_reset();
    #1;
    check("reset_rd0_vld",  64'(rd0_vld),  64'(0));
    check("reset_rd0_data", 64'(rd0_data), 64'(0));
    check("reset_rd1_rdy",  64'(rd1_rdy),  64'(0));
    #11 rst_n = 1'b1;

    // 1. mid-run reset clears r3 and sets it ready
    idle(); wr_en = 1; wr_addr = 3; wr_data = 32'hDEADBEEF; step();
    read0(3);
    check("pre_reset_r3", 64'(rd0_data), 64'h0000_0000_DEAD_BEEF);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_vld",  64'(rd0_vld),  64'(0));
    check("async_rst_data", 64'(rd0_data), 64'(0));
    check("async_rst_rdy",  64'(rd0_rdy),  64'(0));
    model_reset();
    #2 rst_n = 1'b1;
    read0(3);
    check("post_reset_r3_data", 64'(rd0_data), 64'(0));
    check("post_reset_r3_rdy",  64'(rd0_rdy),  64'(1));

    // 2. write then read next cycle
    idle(); wr_en = 1; wr_addr = 5; wr_data = 32'hCAFEBABE; step();
    read0(5);
    check("lat_r5_data", 64'(rd0_data), 64'h0000_0000_CAFE_BABE);

    // 3. bypass on port 1
    idle(); wr_en = 1; wr_addr = 2; wr_data = 32'h11111111; step();
    idle(); wr_en = 1; wr_addr = 2; wr_data = 32'h12345678;
    rd1_en = 1; rd1_addr = 2; step();
    check("bypass_r2_data", 64'(rd1_data), 64'h0000_0000_1234_5678);

    // 4. r0 ignores writes
    idle(); wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; step();
    idle(); rd0_en = 1; rd1_en = 1; step();
    check("r0_p0_data", 64'(rd0_data), 64'(0));
    check("r0_p1_rdy",  64'(rd1_rdy),  64'(1));

    // 5. scoreboard
    idle(); alloc_en = 1; alloc_addr = 4; step();
    read0(4);
    check("sb_alloc_rdy", 64'(rd0_rdy), 64'(0));
    idle(); wr_en = 1; wr_addr = 4; wr_data = 32'hA5A5A5A5; step();
    read0(4);
    check("sb_write_rdy",  64'(rd0_rdy),  64'(1));
    check("sb_write_data", 64'(rd0_data), 64'h0000_0000_A5A5_A5A5);
    idle(); wr_en = 1; wr_addr = 4; wr_data = 32'h5A5A5A5A;
    alloc_en = 1; alloc_addr = 4; rd1_en = 1; rd1_addr = 4; step();
    check("sb_alloc_wins_rdy", 64'(rd1_rdy), 64'(0));
    read0(4);
    check("sb_alloc_wins_held", 64'(rd0_rdy), 64'(0));

    // 6. random vectors against the model
    for (int n = 0; n < 200; n++) begin
      wr_en      = ($urandom_range(0, 3) != 0);
      wr_addr    = AW'($urandom_range(0, NREGS - 1));
      wr_data    = $urandom;
      alloc_en   = ($urandom_range(0, 2) == 0);
      alloc_addr = AW'($urandom_range(0, NREGS - 1));
      rd0_en     = ($urandom_range(0, 3) != 0);
      rd0_addr   = AW'($urandom_range(0, NREGS - 1));
      rd1_en     = ($urandom_range(0, 3) != 0);
      rd1_addr   = ($urandom_range(0, 3) == 0) ? rd0_addr : AW'($urandom_range(0, NREGS - 1));
      step();
    end
    idle(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
